// File: rtl/video_timing_gen.sv
// Video timing generator: raster counters with registered sync/blank/DE decode
// and an 8-bar colour test pattern, all advancing only on the pixel clock enable.
module video_timing_gen #(
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cen_i,
    output logic [2:0]  dvh_sync_o,
    output logic [1:0]  vh_blank_o,
    output logic [23:0] vid_rgb_o,
    output logic        sof_o,
    output logic [15:0] frame_cnt_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_MAX   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_MAX   = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT   = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT   = 12'(V_ACTIVE);
    localparam logic [11:0] HS_BEG  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END  = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_BEG  = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END  = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] BAR_MAX = 12'(H_ACTIVE / 8 - 1);

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    // Bar position tracked incrementally so no divider is needed for h_cnt/bar_width.
    logic [11:0] bar_pix;
    logic [2:0]  bar_idx;

    logic        h_last;
    logic        v_last;
    logic        hblank;
    logic        vblank;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic [23:0] bar_rgb;

    always_comb begin
        h_last = (h_cnt == H_MAX);
        v_last = (v_cnt == V_MAX);
        hblank = (h_cnt >= H_ACT);
        vblank = (v_cnt >= V_ACT);
        de     = !hblank && !vblank;
        hsync  = ((h_cnt >= HS_BEG) && (h_cnt < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vsync  = ((v_cnt >= VS_BEG) && (v_cnt < VS_END)) ? SYNC_POL : ~SYNC_POL;
        case (bar_idx)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            bar_pix     <= '0;
            bar_idx     <= '0;
            frame_cnt_o <= '0;
            dvh_sync_o  <= {1'b0, ~SYNC_POL, ~SYNC_POL};
            vh_blank_o  <= 2'b00;
            vid_rgb_o   <= '0;
            sof_o       <= 1'b0;
        end else if (cen_i) begin
            // Outputs reflect the counter state before this edge.
            dvh_sync_o <= {de, vsync, hsync};
            vh_blank_o <= {vblank, hblank};
            vid_rgb_o  <= de ? bar_rgb : 24'h000000;
            sof_o      <= (h_cnt == 12'd0) && (v_cnt == 12'd0);

            if (h_last) begin
                h_cnt   <= '0;
                bar_pix <= '0;
                bar_idx <= '0;
                if (v_last) begin
                    v_cnt       <= '0;
                    frame_cnt_o <= frame_cnt_o + 16'd1;
                end else begin
                    v_cnt <= v_cnt + 12'd1;
                end
            end else begin
                h_cnt <= h_cnt + 12'd1;
                if (bar_pix == BAR_MAX) begin
                    bar_pix <= '0;
                    bar_idx <= bar_idx + 3'd1;
                end else begin
                    bar_pix <= bar_pix + 12'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: full-size line checks plus reduced-geometry
// frame, enable-toggle, mid-frame reset, polarity and frame-counter wrap scenarios.
module tb_video_timing_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cen = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [2:0] a_dvh, b_dvh, c_dvh, d_dvh;
    logic [1:0] a_blk, b_blk, c_blk, d_blk;
    logic [23:0] a_rgb, b_rgb, c_rgb, d_rgb;
    logic a_sof, b_sof, c_sof, d_sof;
    logic [15:0] a_frm, b_frm, c_frm, d_frm;

    // Full 1080p geometry
    video_timing_gen dut_a (
        .clk_i(clk), .rst_i(rst), .cen_i(cen), .dvh_sync_o(a_dvh), .vh_blank_o(a_blk),
        .vid_rgb_o(a_rgb), .sof_o(a_sof), .frame_cnt_o(a_frm));

    // Reduced geometry: H 16/2/3/4 (25), V 6/1/2/3 (12), 300 cycles per frame
    video_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4), .V_ACTIVE(6),
        .V_FP(1), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1)) dut_b (
        .clk_i(clk), .rst_i(rst), .cen_i(cen), .dvh_sync_o(b_dvh), .vh_blank_o(b_blk),
        .vid_rgb_o(b_rgb), .sof_o(b_sof), .frame_cnt_o(b_frm));

    video_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4), .V_ACTIVE(6),
        .V_FP(1), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)) dut_c (
        .clk_i(clk), .rst_i(rst), .cen_i(cen), .dvh_sync_o(c_dvh), .vh_blank_o(c_blk),
        .vid_rgb_o(c_rgb), .sof_o(c_sof), .frame_cnt_o(c_frm));

    // Smallest legal geometry: 11 x 5 = 55 cycles per frame
    video_timing_gen #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(1), .V_ACTIVE(2),
        .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)) dut_d (
        .clk_i(clk), .rst_i(rst), .cen_i(cen), .dvh_sync_o(d_dvh), .vh_blank_o(d_blk),
        .vid_rgb_o(d_rgb), .sof_o(d_sof), .frame_cnt_o(d_frm));

    localparam int S_HT = 25;
    localparam int S_VT = 12;

    int eh, ev, ef;
    logic [29:0] expb, expc;
    int de_cnt, vs_cnt;

    function automatic logic [23:0] bar_col(int i);
        case (i)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [29:0] rst_val(bit pol);
        return {1'b0, ~pol, ~pol, 2'b00, 24'h0, 1'b0};
    endfunction

    // Expected {de,vs,hs,vblank,hblank,rgb,sof} for the reduced geometry
    function automatic logic [29:0] exp_small(int h, int v, bit pol);
        logic hb, vb, de, hs, vs, sof;
        logic [23:0] rgb;
        hb  = (h >= 16);
        vb  = (v >= 6);
        de  = !hb && !vb;
        hs  = (h >= 18 && h < 21) ? pol : ~pol;
        vs  = (v >= 7 && v < 9) ? pol : ~pol;
        rgb = de ? bar_col(h / 2) : 24'h0;
        sof = (h == 0) && (v == 0);
        return {de, vs, hs, vb, hb, rgb, sof};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cen = 1'b1;
        tick();
        rst = 1'b0;
        cen = 1'b0;
        eh = 0; ev = 0; ef = 0;
        expb = rst_val(1'b1);
        expc = rst_val(1'b0);
    endtask

    task automatic run_small(int n, bit toggle);
        logic [29:0] gb, gc;
        bit en;
        for (int i = 0; i < n; i++) begin
            en = toggle ? (i % 2 == 0) : 1'b1;
            cen = en;
            tick();
            if (en) begin
                expb = exp_small(eh, ev, 1'b1);
                expc = exp_small(eh, ev, 1'b0);
                if (eh == S_HT - 1) begin
                    eh = 0;
                    if (ev == S_VT - 1) begin
                        ev = 0;
                        ef = ef + 1;
                    end else ev = ev + 1;
                end else eh = eh + 1;
                if (b_dvh[2]) de_cnt++;
                if (!c_dvh[1]) vs_cnt++;
            end
            gb = {b_dvh, b_blk, b_rgb, b_sof};
            gc = {c_dvh, c_blk, c_rgb, c_sof};
            n_cmp += 4;
            if (gb !== expb) begin
                n_bad++; $display("FAIL small_pos_out step=%0d got=%h exp=%h", i, gb, expb);
            end
            if (b_frm !== 16'(ef)) begin
                n_bad++; $display("FAIL small_pos_frame step=%0d got=%0d exp=%0d", i, b_frm, ef);
            end
            if (gc !== expc) begin
                n_bad++; $display("FAIL small_neg_out step=%0d got=%h exp=%h", i, gc, expc);
            end
            if (c_frm !== 16'(ef)) begin
                n_bad++; $display("FAIL small_neg_frame step=%0d got=%0d exp=%0d", i, c_frm, ef);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cen = 1'b0;
        tick();
        tick();
        n_cmp += 5;
        if ({a_dvh, a_blk, a_rgb, a_sof} !== 30'h0) begin
            n_bad++; $display("FAIL reset_a_out got=%h exp=0", {a_dvh, a_blk, a_rgb, a_sof});
        end
        if (a_frm !== 16'h0) begin
            n_bad++; $display("FAIL reset_a_frame got=%h exp=0", a_frm);
        end
        if ({c_dvh, c_blk, c_rgb, c_sof} !== rst_val(1'b0)) begin
            n_bad++; $display("FAIL reset_neg_out got=%h exp=%h", {c_dvh, c_blk, c_rgb, c_sof}, rst_val(1'b0));
        end
        if ({d_dvh, d_blk, d_rgb, d_sof} !== 30'h0) begin
            n_bad++; $display("FAIL reset_d_out got=%h exp=0", {d_dvh, d_blk, d_rgb, d_sof});
        end
        if ({b_frm, d_frm} !== 32'h0) begin
            n_bad++; $display("FAIL reset_frames got=%h exp=0", {b_frm, d_frm});
        end
        rst = 1'b0;
    endtask

    task automatic test_first_pixel();
        cen = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({a_dvh, a_blk, a_rgb, a_sof} !== 30'h0) begin
            n_bad++; $display("FAIL hold_after_reset got=%h exp=0", {a_dvh, a_blk, a_rgb, a_sof});
        end
        cen = 1'b1;
        tick();
        n_cmp += 3;
        if ({a_dvh, a_blk, a_sof} !== {3'b100, 2'b00, 1'b1}) begin
            n_bad++; $display("FAIL first_pixel_ctl got=%b exp=100001", {a_dvh, a_blk, a_sof});
        end
        if (a_rgb !== 24'hFFFFFF) begin
            n_bad++; $display("FAIL first_pixel_rgb got=%h exp=FFFFFF", a_rgb);
        end
        if (c_dvh !== 3'b111) begin
            n_bad++; $display("FAIL first_pixel_neg_sync got=%b exp=111", c_dvh);
        end
        tick();
        n_cmp++;
        if (a_sof !== 1'b0) begin
            n_bad++; $display("FAIL sof_single got=%b exp=0", a_sof);
        end
    endtask

    task automatic test_line0();
        int de_n, hs_n, hs_first;
        logic [23:0] want;
        de_n = 0; hs_n = 0; hs_first = -1;
        do_reset();
        cen = 1'b1;
        for (int k = 0; k <= 2200; k++) begin
            tick();
            if (k < 2200) begin
                if (a_dvh[2]) de_n++;
                if (a_dvh[0]) begin
                    hs_n++;
                    if (hs_first < 0) hs_first = k;
                end
            end
            if (k == 0 || k == 239 || k == 240 || k == 1679 || k == 1680 || k == 1919) begin
                case (k)
                    0, 239:     want = 24'hFFFFFF;
                    240:        want = 24'hFFFF00;
                    1679:       want = 24'h0000FF;
                    default:    want = 24'h000000;
                endcase
                n_cmp++;
                if (a_rgb !== want) begin
                    n_bad++; $display("FAIL line0_rgb h=%0d got=%h exp=%h", k, a_rgb, want);
                end
            end
            if (k == 1920) begin
                n_cmp++;
                if ({a_dvh[2], a_blk, a_rgb} !== {1'b0, 2'b01, 24'h0}) begin
                    n_bad++; $display("FAIL line0_h1920 got=%h exp=%h", {a_dvh[2], a_blk, a_rgb}, {1'b0, 2'b01, 24'h0});
                end
            end
            if (k == 2100) begin
                n_cmp++;
                if (a_dvh[1] !== 1'b0) begin
                    n_bad++; $display("FAIL line0_vsync_idle got=%b exp=0", a_dvh[1]);
                end
            end
            if (k == 2200) begin
                n_cmp++;
                if ({a_dvh[2], a_blk, a_sof} !== 4'b1000) begin
                    n_bad++; $display("FAIL line1_start got=%b exp=1000", {a_dvh[2], a_blk, a_sof});
                end
            end
        end
        n_cmp += 3;
        if (de_n !== 1920) begin
            n_bad++; $display("FAIL line0_de_count got=%0d exp=1920", de_n);
        end
        if (hs_n !== 44) begin
            n_bad++; $display("FAIL line0_hsync_count got=%0d exp=44", hs_n);
        end
        if (hs_first !== 2008) begin
            n_bad++; $display("FAIL line0_hsync_start got=%0d exp=2008", hs_first);
        end
    endtask

    task automatic test_frames();
        do_reset();
        de_cnt = 0; vs_cnt = 0;
        run_small(900, 1'b0);
        n_cmp += 2;
        if (de_cnt !== 288) begin
            n_bad++; $display("FAIL frames_de_count got=%0d exp=288", de_cnt);
        end
        if (vs_cnt !== 150) begin
            n_bad++; $display("FAIL frames_vsync_low_count got=%0d exp=150", vs_cnt);
        end
        run_small(1, 1'b0);
        n_cmp++;
        if ({b_sof, b_frm} !== {1'b1, 16'd3}) begin
            n_bad++; $display("FAIL frames_sof_count got=%h exp=%h", {b_sof, b_frm}, {1'b1, 16'd3});
        end
    endtask

    task automatic test_cen_toggle();
        do_reset();
        de_cnt = 0;
        run_small(602, 1'b1);
        n_cmp++;
        if (de_cnt !== 97) begin
            n_bad++; $display("FAIL toggle_de_count got=%0d exp=97", de_cnt);
        end
    endtask

    task automatic test_midframe_reset();
        do_reset();
        run_small(383, 1'b0);
        n_cmp++;
        if (b_frm !== 16'd1) begin
            n_bad++; $display("FAIL midframe_pre_frame got=%0d exp=1", b_frm);
        end
        rst = 1'b1;
        cen = 1'b0;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({b_dvh, b_blk, b_rgb, b_sof, b_frm} !== {rst_val(1'b1), 16'd0}) begin
            n_bad++; $display("FAIL midframe_reset_out got=%h exp=%h", {b_dvh, b_blk, b_rgb, b_sof, b_frm}, {rst_val(1'b1), 16'd0});
        end
        eh = 0; ev = 0; ef = 0;
        expb = rst_val(1'b1);
        expc = rst_val(1'b0);
        run_small(1, 1'b0);
        n_cmp++;
        if ({b_sof, b_dvh[2], b_frm} !== {2'b11, 16'd0}) begin
            n_bad++; $display("FAIL midframe_restart got=%h exp=%h", {b_sof, b_dvh[2], b_frm}, {2'b11, 16'd0});
        end
    endtask

    task automatic test_frame_wrap();
        bit seen;
        do_reset();
        cen = 1'b1;
        for (int i = 0; i < 60; i++) tick();
        n_cmp++;
        if (d_frm !== 16'd1) begin
            n_bad++; $display("FAIL wrap_first_frame got=%0d exp=1", d_frm);
        end
        force dut_d.frame_cnt_o = 16'hFFFF;
        tick();
        tick();
        release dut_d.frame_cnt_o;
        tick();
        n_cmp++;
        if (d_frm !== 16'hFFFF) begin
            n_bad++; $display("FAIL wrap_preload got=%h exp=FFFF", d_frm);
        end
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            seen = d_sof;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++; $display("FAIL wrap_sof_timeout got=none exp=sof within 100 cycles");
        end else if (d_frm !== 16'h0000) begin
            n_bad++; $display("FAIL wrap_value got=%h exp=0000", d_frm);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_pixel();
        test_line0();
        test_frames();
        test_cen_toggle();
        test_midframe_reset();
        test_frame_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
